// File: rtl/video_timing_pkg.sv
// Shared constants for the video timing generator: default 1024x768@60 timing,
// pixel width and the colour-bar palette used by the optional test pattern.
package video_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 1024;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 136;
  localparam int unsigned DEF_H_BP     = 160;
  localparam int unsigned DEF_V_ACTIVE = 768;
  localparam int unsigned DEF_V_FP     = 3;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 29;
  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned DEF_PIX_W           = 24;
  localparam logic [23:0] DEF_UNDERFLOW_COLOR = 24'hFF00FF;

  localparam int unsigned NUM_BARS = 8;

  typedef enum logic [2:0] {
    BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
    BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK
  } bar_e;

  // RGB888 colour of a bar, left to right
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (bar_e'(idx))
      BAR_WHITE:   bar_color = 24'hFFFFFF;
      BAR_YELLOW:  bar_color = 24'hFFFF00;
      BAR_CYAN:    bar_color = 24'h00FFFF;
      BAR_GREEN:   bar_color = 24'h00FF00;
      BAR_MAGENTA: bar_color = 24'hFF00FF;
      BAR_RED:     bar_color = 24'hFF0000;
      BAR_BLUE:    bar_color = 24'h0000FF;
      default:     bar_color = 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Upstream pixel stream: source drives pixel/valid, timing generator returns ready.
interface video_timing_if #(
  parameter int unsigned PIX_W = video_timing_pkg::DEF_PIX_W
) ();

  logic [PIX_W-1:0] pixel_in;
  logic             pixel_valid;
  logic             pixel_ready;

  modport master (output pixel_in, output pixel_valid, input pixel_ready);
  modport slave  (input pixel_in, input pixel_valid, output pixel_ready);

endinterface

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters; held at (0,0) while disabled or in reset.
module video_timing_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL = DEF_H_TOTAL,
  parameter int unsigned V_TOTAL = DEF_V_TOTAL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  output logic [$clog2(H_TOTAL)-1:0] h_cnt,
  output logic [$clog2(V_TOTAL)-1:0] v_cnt,
  output logic                       frame_end_c
);

  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic line_end_c;

  assign line_end_c  = (h_cnt == H_LAST);
  assign frame_end_c = line_end_c && (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end_c) begin
      h_cnt <= '0;
      v_cnt <= frame_end_c ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with pixel pull interface, registered DVI-side outputs.
// Define VIDEO_TIMING_TEST_PATTERN_EN to build the internal colour-bar source.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PIX_W    = DEF_PIX_W,
  parameter logic [PIX_W-1:0] UNDERFLOW_COLOR = PIX_W'(DEF_UNDERFLOW_COLOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  video_timing_if.slave    pix,
  output logic [PIX_W-1:0] video_data,
  output logic             video_de,
  output logic             video_hsync,
  output logic             video_vsync,
  output logic             frame_start,
  output logic [15:0]      frame_count,
  output logic             underflow,
  input  logic             underflow_clr,
  input  logic             test_pattern
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0]    h_cnt;
  logic [VW-1:0]    v_cnt;
  logic             frame_end_c;
  logic             active_c;
  logic             hs_on_c;
  logic             vs_on_c;
  logic             pattern_c;
  logic [PIX_W-1:0] pattern_pix_c;
  logic             starve_c;

  video_timing_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .frame_end_c (frame_end_c)
  );

  assign active_c = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_on_c  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_on_c  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACTIVE / NUM_BARS > 0) ? H_ACTIVE / NUM_BARS : 1;

  logic [31:0] bar_pos_c;
  logic [2:0]  bar_idx_c;

  // Any remainder pixels past the eighth bar stay black
  assign bar_pos_c     = 32'(h_cnt) / BAR_W;
  assign bar_idx_c     = (bar_pos_c > 32'd7) ? 3'd7 : bar_pos_c[2:0];
  assign pattern_c     = test_pattern;
  assign pattern_pix_c = PIX_W'(bar_color(bar_idx_c));
`else
  logic tp_unused;

  assign tp_unused     = test_pattern;
  assign pattern_c     = 1'b0;
  assign pattern_pix_c = '0;
`endif

  // Reset gates ready so nothing is consumed on a cycle whose output is discarded
  assign pix.pixel_ready = en && !rst && active_c && !pattern_c;
  assign starve_c        = en && active_c && !pattern_c && !pix.pixel_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      video_data  <= '0;
      video_de    <= 1'b0;
      video_hsync <= ~HS_POL;
      video_vsync <= ~VS_POL;
      frame_start <= 1'b0;
      frame_count <= '0;
      underflow   <= 1'b0;
    end else begin
      video_de    <= en && active_c;
      video_hsync <= (en && hs_on_c) ? HS_POL : ~HS_POL;
      video_vsync <= (en && vs_on_c) ? VS_POL : ~VS_POL;
      frame_start <= en && (h_cnt == '0) && (v_cnt == '0);

      if (!en || !active_c)       video_data <= '0;
      else if (pattern_c)         video_data <= pattern_pix_c;
      else if (pix.pixel_valid)   video_data <= pix.pixel_in;
      else                        video_data <= UNDERFLOW_COLOR;

      if (en && frame_end_c)      frame_count <= frame_count + 16'd1;

      if (starve_c)               underflow <= 1'b1;
      else if (underflow_clr)     underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a 14x7 raster: directed table, scenario sequences
// and random stimulus checked against a linear-position frame model.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  localparam bit TP_BUILD = 1'b1;
`else
  localparam bit TP_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, underflow_clr, test_pattern;
  logic [23:0] video_data;
  logic        video_de, video_hsync, video_vsync, frame_start, underflow;
  logic [15:0] frame_count;

  video_timing_if #(.PIX_W(24)) pix ();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_W(24), .UNDERFLOW_COLOR(24'hFF00FF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .pix           (pix),
    .video_data    (video_data),
    .video_de      (video_de),
    .video_hsync   (video_hsync),
    .video_vsync   (video_vsync),
    .frame_start   (frame_start),
    .frame_count   (frame_count),
    .underflow     (underflow),
    .underflow_clr (underflow_clr),
    .test_pattern  (test_pattern)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: position within the frame as a single raster index, plus frames and flag
  int          m_pos = 0;
  int          m_frames = 0;
  bit          m_uf = 1'b0;
  logic [23:0] e_data;
  bit          e_de, e_fs, e_hs, e_vs;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct {
    bit          r, e, v;
    logic [23:0] p;
    bit          c;
    logic [23:0] x_data;
    bit          x_de, x_fs, x_hs, x_vs, x_uf;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, check ready, predict, clock, check registered outputs
  task automatic cycle(input bit r, input bit e, input bit v, input logic [23:0] p,
                       input bit c, input bit t);
    int h, vl;
    bit act, tp;
    rst = r; en = e; pix.pixel_valid = v; pix.pixel_in = p;
    underflow_clr = c; test_pattern = t;
    tp = t && TP_BUILD;
    h  = m_pos % HT;
    vl = m_pos / HT;
    act = (h < HA) && (vl < VA);
    #1;
    chk("pixel_ready", 32'(pix.pixel_ready), 32'(!r && e && act && !tp));
    if (r) begin
      e_data = '0; e_de = 0; e_fs = 0; e_hs = 1; e_vs = 1;
      m_pos = 0; m_frames = 0; m_uf = 0;
    end else if (!e) begin
      e_data = '0; e_de = 0; e_fs = 0; e_hs = 1; e_vs = 1;
      m_pos = 0;
      if (c) m_uf = 0;
    end else begin
      e_de = act;
      e_fs = (m_pos == 0);
      e_hs = !(h >= HA + HF && h < HA + HF + HS);
      e_vs = !(vl >= VA + VF && vl < VA + VF + VS);
      if (!act)     e_data = '0;
      else if (tp)  e_data = bars[h / (HA / 8)];
      else if (v)   e_data = p;
      else          e_data = 24'hFF00FF;
      if (act && !v && !tp) m_uf = 1;
      else if (c)           m_uf = 0;
      m_pos++;
      if (m_pos == FT) begin
        m_pos = 0;
        m_frames = (m_frames + 1) % 65536;
      end
    end
    @(posedge clk);
    #1;
    chk("video_data", 32'(video_data), 32'(e_data));
    chk("video_de", 32'(video_de), 32'(e_de));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("video_hsync", 32'(video_hsync), 32'(e_hs));
    chk("video_vsync", 32'(video_vsync), 32'(e_vs));
    chk("frame_count", 32'(frame_count), 32'(m_frames));
    chk("underflow", 32'(underflow), 32'(m_uf));
  endtask

  initial begin
    int de_cnt, hs_low, vs_low, fs_cnt, fs_first, fs_last, idle_de;
    logic [15:0] fc_saved;

    //          r  e  v  p         c  data       de fs hs vs uf
    tbl[0] = '{1, 0, 0, 24'h0,     0, 24'h0,     0, 0, 1, 1, 0};
    tbl[1] = '{1, 1, 1, 24'h5,     1, 24'h0,     0, 0, 1, 1, 0};
    tbl[2] = '{0, 1, 1, 24'hA1A1A1, 0, 24'hA1A1A1, 1, 1, 1, 1, 0};
    tbl[3] = '{0, 1, 0, 24'h123456, 0, 24'hFF00FF, 1, 0, 1, 1, 1};
    tbl[4] = '{0, 1, 1, 24'hB2B2B2, 1, 24'hB2B2B2, 1, 0, 1, 1, 0};
    tbl[5] = '{0, 1, 0, 24'h777777, 1, 24'hFF00FF, 1, 0, 1, 1, 1};
    tbl[6] = '{0, 0, 1, 24'h888888, 0, 24'h0,     0, 0, 1, 1, 1};
    tbl[7] = '{0, 1, 1, 24'hC3C3C3, 0, 24'hC3C3C3, 1, 1, 1, 1, 1};
    tbl[8] = '{1, 1, 1, 24'hD4D4D4, 0, 24'h0,     0, 0, 1, 1, 0};

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].p, tbl[i].c, 1'b0);
      chk("tbl_data", 32'(video_data), 32'(tbl[i].x_data));
      chk("tbl_de", 32'(video_de), 32'(tbl[i].x_de));
      chk("tbl_fs", 32'(frame_start), 32'(tbl[i].x_fs));
      chk("tbl_hs", 32'(video_hsync), 32'(tbl[i].x_hs));
      chk("tbl_vs", 32'(video_vsync), 32'(tbl[i].x_vs));
      chk("tbl_uf", 32'(underflow), 32'(tbl[i].x_uf));
    end

    // Free-run three frames with pixel_in = raster index
    de_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; fs_first = -1; fs_last = -1;
    for (int i = 0; i < 3 * FT; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 24'(i % FT), 1'b0, 1'b0);
      de_cnt += int'(video_de);
      hs_low += int'(!video_hsync);
      vs_low += int'(!video_vsync);
      if (frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
        fs_last = i;
      end
    end
    chk("run_frame_count", 32'(frame_count), 32'd3);
    chk("run_de_cycles", 32'(de_cnt), 32'd96);
    chk("run_hsync_low", 32'(hs_low), 32'd42);
    chk("run_vsync_low", 32'(vs_low), 32'd42);
    chk("run_fs_pulses", 32'(fs_cnt), 32'd3);
    chk("run_fs_span", 32'(fs_last - fs_first), 32'(2 * FT));

    // Drop en at (3,2) after one full frame, resume 5 cycles later
    cycle(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    for (int i = 0; i < FT + 2 * HT + 3; i++)
      cycle(1'b0, 1'b1, 1'b1, 24'(i), 1'b0, 1'b0);
    fc_saved = frame_count;
    chk("drop_fc_before", 32'(fc_saved), 32'd1);
    idle_de = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
      idle_de += int'(video_de) + int'(frame_start) + int'(!video_hsync) + int'(!video_vsync);
    end
    chk("drop_idle", 32'(idle_de), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 24'hABCDEF, 1'b0, 1'b0);
    chk("drop_restart_fs", 32'(frame_start), 32'd1);
    chk("drop_restart_data", 32'(video_data), 32'hABCDEF);
    chk("drop_fc_kept", 32'(frame_count), 32'(fc_saved));

    // Reset pulsed mid-line with en held high
    for (int i = 0; i < 20; i++)
      cycle(1'b0, 1'b1, 1'b1, 24'(i + 100), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 24'h999999, 1'b0, 1'b0);
    chk("rst_data", 32'(video_data), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_hsync", 32'(video_hsync), 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 24'h135790, 1'b0, 1'b0);
    chk("rst_restart_fs", 32'(frame_start), 32'd1);
    chk("rst_restart_data", 32'(video_data), 32'h135790);

    // Random traffic against the model
    for (int i = 0; i < 900; i++)
      cycle(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 24) != 0),
            1'($urandom_range(0, 3) != 0), 24'($urandom), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 3) == 0));

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    // Colour bars: one pixel per bar, source ignored and never starved
    cycle(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    for (int i = 0; i < FT; i++) begin
      cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 24'($urandom), 1'b0, 1'b1);
      if (i < HA) chk("tp_bar", 32'(video_data), 32'(bars[i]));
    end
    chk("tp_underflow", 32'(underflow), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
